// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands are registered toward the ALU, and each result is returned as a tagged response.
module alu_arbiter #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned OPW   = 3,
    parameter int unsigned CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_cout,
    output logic             busy,
    output logic [CNTW-1:0]  grant_cnt0,
    output logic [CNTW-1:0]  grant_cnt1
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [OPW-1:0]   alu_op_q, alu_op_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_y_q, rsp_y_d;
    logic             rsp_cout_q, rsp_cout_d;
    logic [CNTW-1:0]  cnt0_q, cnt0_d;
    logic [CNTW-1:0]  cnt1_q, cnt1_d;

    logic win_valid;
    logic win_id;
    logic accept;

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        win_valid = req0_valid | req1_valid;
        win_id    = 1'b0;
        if (req0_valid && req1_valid) begin
            win_id = ~last_grant_q;
        end else if (req1_valid) begin
            win_id = 1'b1;
        end
    end

    assign accept     = (state_q == StIdle) && win_valid;
    assign req0_ready = rst_n & accept & ~win_id;
    assign req1_ready = rst_n & accept & win_id;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_id_d     = rsp_id_q;
        rsp_y_d      = rsp_y_q;
        rsp_cout_d   = rsp_cout_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    alu_a_d      = win_id ? req1_a : req0_a;
                    alu_b_d      = win_id ? req1_b : req0_b;
                    alu_op_d     = win_id ? req1_op : req0_op;
                    rsp_id_d     = win_id;
                    last_grant_d = win_id;
                    if (!win_id && cnt0_q != {CNTW{1'b1}}) begin
                        cnt0_d = cnt0_q + CNTW'(1);
                    end
                    if (win_id && cnt1_q != {CNTW{1'b1}}) begin
                        cnt1_d = cnt1_q + CNTW'(1);
                    end
                    state_d = StExec;
                end
            end
            StExec: begin
                rsp_y_d    = alu_y;
                // Logic ops have no meaningful carry.
                rsp_cout_d = alu_op_q[OPW-1] ? 1'b0 : alu_cout;
                state_d    = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_id_q     <= 1'b0;
            rsp_y_q      <= '0;
            rsp_cout_q   <= 1'b0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_id_q     <= rsp_id_d;
            rsp_y_q      <= rsp_y_d;
            rsp_cout_q   <= rsp_cout_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign rsp_valid  = (state_q == StResp);
    assign rsp_id     = rsp_id_q;
    assign rsp_y      = rsp_y_q;
    assign rsp_cout   = rsp_cout_q;
    assign busy       = (state_q != StIdle);
    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU on the alu_* side.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0]  req0_op = '0, req1_op = '0;
    logic [15:0] alu_a, alu_b, alu_y;
    logic [2:0]  alu_op;
    logic        alu_cout;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_cout, busy;
    logic [15:0] rsp_y;
    logic [7:0]  grant_cnt0, grant_cnt1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_y      (alu_y),
        .alu_cout   (alu_cout),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_y      (rsp_y),
        .rsp_cout   (rsp_cout),
        .busy       (busy),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );

    // Logic ops drive cout high so the arbiter's masking is observable.
    always_comb begin
        alu_y    = '0;
        alu_cout = 1'b0;
        case (alu_op)
            3'b000: {alu_cout, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
            3'b001: {alu_cout, alu_y} = {1'b0, alu_a} - {1'b0, alu_b};
            3'b100: begin alu_y = alu_a & alu_b; alu_cout = 1'b1; end
            3'b101: begin alu_y = alu_a | alu_b; alu_cout = 1'b1; end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
        chk("ready_exclusive", 32'(req0_ready & req1_ready), 32'(0));
    endtask

    initial begin
        // Reset with a pending request: nothing may be granted.
        req0_valid = 1'b1;
        step();
        chk("rst_req0_ready", 32'(req0_ready), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_alu_a", 32'(alu_a), 32'(0));
        chk("rst_cnt0", 32'(grant_cnt0), 32'(0));
        chk("rst_cnt1", 32'(grant_cnt1), 32'(0));

        // First op from requester 0: add with carry.
        req0_a = 16'h8F54; req0_b = 16'h79F8; req0_op = 3'b000; rsp_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        chk("t1_req0_ready", 32'(req0_ready), 32'(1));
        step();
        req0_valid = 1'b0;
        chk("t1_busy", 32'(busy), 32'(1));
        chk("t1_alu_a", 32'(alu_a), 32'h8F54);
        chk("t1_cnt0", 32'(grant_cnt0), 32'(1));
        chk("t1_ready_exec", 32'(req0_ready), 32'(0));
        step();
        chk("t1_rsp_valid", 32'(rsp_valid), 32'(1));
        chk("t1_rsp_id", 32'(rsp_id), 32'(0));
        chk("t1_rsp_y", 32'(rsp_y), 32'h094C);
        chk("t1_rsp_cout", 32'(rsp_cout), 32'(1));
        step();
        chk("t1_idle_valid", 32'(rsp_valid), 32'(0));
        chk("t1_idle_busy", 32'(busy), 32'(0));

        // Requester 1 alone: logic op, carry forced low.
        req1_a = 16'h93D2; req1_b = 16'hED97; req1_op = 3'b100; req1_valid = 1'b1;
        #1;
        chk("t2_req1_ready", 32'(req1_ready), 32'(1));
        chk("t2_req0_ready", 32'(req0_ready), 32'(0));
        step();
        req1_valid = 1'b0;
        step();
        chk("t2_rsp_valid", 32'(rsp_valid), 32'(1));
        chk("t2_rsp_id", 32'(rsp_id), 32'(1));
        chk("t2_rsp_y", 32'(rsp_y), 32'h8192);
        chk("t2_rsp_cout", 32'(rsp_cout), 32'(0));
        chk("t2_cnt1", 32'(grant_cnt1), 32'(1));
        step();

        // Sustained dual requests: strict alternation, one response per 3 cycles.
        req0_a = 16'h0005; req0_b = 16'h0003; req0_op = 3'b001;
        req1_a = 16'h0003; req1_b = 16'h0005; req1_op = 3'b001;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            chk("rr_req0_ready", 32'(req0_ready), 32'((i % 2) == 0));
            chk("rr_req1_ready", 32'(req1_ready), 32'((i % 2) == 1));
            step();
            step();
            chk("rr_rsp_valid", 32'(rsp_valid), 32'(1));
            chk("rr_rsp_id", 32'(rsp_id), 32'(i % 2));
            chk("rr_rsp_y", 32'(rsp_y), (i % 2) ? 32'hFFFE : 32'h0002);
            chk("rr_rsp_cout", 32'(rsp_cout), 32'(i % 2));
            step();
        end
        chk("rr_cnt0", 32'(grant_cnt0), 32'(4));
        chk("rr_cnt1", 32'(grant_cnt1), 32'(4));

        // Backpressure in RESP: response frozen, no new grants.
        rsp_ready = 1'b0;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            req0_a = 16'h1111 * 16'(i);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'(1));
            chk("bp_rsp_id", 32'(rsp_id), 32'(0));
            chk("bp_rsp_y", 32'(rsp_y), 32'h0002);
            chk("bp_rsp_cout", 32'(rsp_cout), 32'(0));
            chk("bp_readys", 32'({req0_ready, req1_ready}), 32'(0));
            chk("bp_busy", 32'(busy), 32'(1));
            step();
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_idle_valid", 32'(rsp_valid), 32'(0));
        chk("bp_idle_req1_ready", 32'(req1_ready), 32'(1));
        step();
        chk("bp_regrant_busy", 32'(busy), 32'(1));
        chk("bp_regrant_alu_a", 32'(alu_a), 32'h0003);
        chk("bp_cnt0", 32'(grant_cnt0), 32'(5));
        chk("bp_cnt1", 32'(grant_cnt1), 32'(5));
        step();
        step();

        // Asynchronous reset in the middle of EXEC.
        chk("ar_req0_ready", 32'(req0_ready), 32'(1));
        step();
        chk("ar_in_exec", 32'(busy), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_busy", 32'(busy), 32'(0));
        chk("ar_alu_a", 32'(alu_a), 32'(0));
        chk("ar_alu_op", 32'(alu_op), 32'(0));
        chk("ar_cnt0", 32'(grant_cnt0), 32'(0));
        chk("ar_cnt1", 32'(grant_cnt1), 32'(0));
        chk("ar_readys", 32'({req0_ready, req1_ready}), 32'(0));
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("ar_no_rsp", 32'(rsp_valid), 32'(0));
        chk("ar_tie_req0", 32'(req0_ready), 32'(1));
        chk("ar_tie_req1", 32'(req1_ready), 32'(0));

        // Saturation: 260 grants to requester 0 only.
        req1_valid = 1'b0;
        for (int i = 0; i < 260; i++) begin
            step();
            step();
            step();
        end
        chk("sat_cnt0", 32'(grant_cnt0), 32'(255));
        chk("sat_cnt1", 32'(grant_cnt1), 32'(0));
        req0_valid = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 16-bit ALU (operands a/b, 3-bit op, result y, carry cout) between two requesters.
- Each requester submits an operation over a valid/ready handshake. The arbiter grants round-robin, drives the ALU from internal registers, captures y/cout, and returns a tagged response over a valid/ready handshake.
- Sits between the ALU and its two clients (e.g. the instruction sequencer and the test/debug port). Also keeps saturating grant counters for performance monitoring.

Parameters:
WIDTH, 16, operand/result width
OPW, 3, opcode width (op[OPW-1]=0 arithmetic, =1 logic)
CNTW, 8, width of per-requester grant counters

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_a  input  WIDTH  requester 0 operand a
req0_b  input  WIDTH  requester 0 operand b
req0_op  input  OPW  requester 0 opcode
req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0
alu_a  output  WIDTH  registered operand a to ALU
alu_b  output  WIDTH  registered operand b to ALU
alu_op  output  OPW  registered opcode to ALU
alu_y  input  WIDTH  ALU result
alu_cout  input  1  ALU carry/borrow out
rsp_valid  output  1  response available
rsp_ready  input  1  consumer accepts response
rsp_id  output  1  requester that owns the response
rsp_y  output  WIDTH  captured result
rsp_cout  output  1  captured carry
busy  output  1  state != IDLE
grant_cnt0  output  CNTW  grants to requester 0, saturating
grant_cnt1  output  CNTW  grants to requester 1, saturating

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE.
  - All outputs 0, including alu_*, rsp_*, busy and both counters.
  - Internal last_grant=1, so requester 0 wins the first tie.
  - An in-flight operation is dropped with no response. Ready outputs are 0 during reset.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Select a winner: only one valid -> that requester; both valid -> requester != last_grant.
  - reqN_ready is combinational, high only for the winner, and only in IDLE. Never both high.
  - On the accepting edge: latch a/b/op into the alu_* registers, set rsp_id and last_grant to the winner, increment that grant counter (holds at 2^CNTW-1), go to EXEC.
- EXEC:
  - alu_* stay stable from the registers.
  - At the end of EXEC: rsp_y<=alu_y; rsp_cout<=alu_cout if op[OPW-1]=0, else 0. Go to RESP.
- RESP:
  - rsp_valid=1. rsp_id/y/cout held stable until the rsp_ready handshake.
  - On rsp_valid&rsp_ready: go to IDLE, rsp_valid drops next cycle.
  - Backpressure of any length holds RESP, and no new request is accepted.
- alu_* keep their last values in IDLE and RESP; they update only on accept.
- Latency: accept at edge E0, rsp_valid high after E1. With rsp_ready high, IDLE after E2, next accept at E3 at earliest. Minimum 3 cycles per operation.
- Requester inputs are sampled only on the accepting edge. Changes while not ready are ignored.
- Requesters that drop valid before ready receive no grant and no counter increment.
- Sustained dual requests alternate strictly: 0,1,0,1...

Test Plan:
(Bench ALU model: 000=add, 001=sub a-b, 100=AND, 101=OR.)
- After reset release: req0 valid, a=8F54, b=79F8, op=000, rsp_ready=1 -> req0_ready high in first IDLE cycle; rsp_valid two edges later with rsp_id=0, rsp_y=094C, rsp_cout=1; grant_cnt0=1.
- req1 only: a=93D2, b=ED97, op=100 -> rsp_id=1, rsp_y=8192, rsp_cout=0 (forced for logic op even if the model drives 1); grant_cnt1=1.
- Both valid continuously for 6 operations, rsp_ready=1 -> grants 0,1,0,1,0,1; responses every 3 cycles; never both readys high.
- Hold rsp_ready=0 for 5 cycles in RESP while req0/req1 valid -> rsp_valid/id/y/cout stable, readys 0, busy 1; after rsp_ready pulse, next grant occurs exactly one cycle after IDLE is re-entered.
- Assert rst_n=0 asynchronously mid-EXEC -> outputs 0 immediately (no clock edge); no response after release; next tie goes to requester 0.
- Issue 260 req0-only operations -> grant_cnt0 saturates at 255; grant_cnt1 stays 0.
